// File: rtl/mult_seq_ctrl.sv
// Iterative unsigned shift-add multiplier (MULTU) with HI/LO registers,
// MFHI/MFLO read-back and a pipeline stall for dependent instructions.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mf_data_o
);

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   prod;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   added;
  logic [2*WIDTH:0]   step;
  logic               accept;
  logic               last;

  // One shift-add iteration; the carry lands in prod[2W] before the shift.
  always_comb begin
    sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    added = prod[0] ? {sum, prod[WIDTH-1:0]} : prod;
    step  = added >> 1;
  end

  assign accept = valid_i && (funct_i == F_MULTU) && (state != RUN);
  assign last   = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      prod   <= '0;
      hi_o   <= '0;
      lo_o   <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        mcand  <= rs_data_i;
        prod   <= {1'b0, {WIDTH{1'b0}}, rt_data_i};
        cnt    <= '0;
        state  <= RUN;
        busy_o <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            prod <= step;
            cnt  <= cnt + CW'(1);
            if (last) begin
              hi_o   <= step[2*WIDTH-1:WIDTH];
              lo_o   <= step[WIDTH-1:0];
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign stall_o = valid_i && busy_o &&
                   ((funct_i == F_MULTU) || (funct_i == F_MFHI) || (funct_i == F_MFLO));

  always_comb begin
    case (funct_i)
      F_MFHI:  mf_data_o = hi_o;
      F_MFLO:  mf_data_o = lo_o;
      default: mf_data_o = '0;
    endcase
  end

endmodule
